// File: rtl/sram_burst_initiator.sv
// Purpose: turns {addr, len, dir} burst commands into one-word-per-cycle SRAM host-side accesses.
// Latency: writes issue in the same cycle as write data; read data returns RD_LAT cycles after o_rden and falls straight through an empty FIFO.
// Backpressure: write stream stalls the burst; read issue is throttled so outstanding reads + buffered words never exceed RD_LAT+2.
// Ports: command (i_cmd_valid/o_cmd_ready, addr, len, write), write stream (valid/ready, data, mask),
//        read stream (valid/ready, data), SRAM host side (o_data, o_address, o_wren, o_wmask, o_rden, i_data_out),
//        status (o_busy, o_done). Single clock i_clk, synchronous active-high reset i_rst.
module sram_burst_initiator #(
    parameter int IF_W     = 32,
    parameter int IF_ADR_W = 32,
    parameter int LEN_W    = 16,
    parameter int RD_LAT   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [IF_ADR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]    i_cmd_len,
    input  logic                i_cmd_write,
    input  logic                i_wdata_valid,
    output logic                o_wdata_ready,
    input  logic [IF_W-1:0]     i_wdata,
    input  logic [IF_W-1:0]     i_wdata_mask,
    output logic                o_rdata_valid,
    input  logic                i_rdata_ready,
    output logic [IF_W-1:0]     o_rdata,
    output logic [IF_W-1:0]     o_data,
    output logic [IF_ADR_W-1:0] o_address,
    output logic                o_wren,
    output logic [IF_W-1:0]     o_wmask,
    output logic                o_rden,
    input  logic [IF_W-1:0]     i_data_out,
    output logic                o_busy,
    output logic                o_done
);
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [IF_ADR_W-1:0] ADDR_STEP   = IF_ADR_W'(IF_W / 8);
    localparam logic [CNT_W:0]      DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]    PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state;
    logic [IF_ADR_W-1:0] cur_addr;
    logic [IF_ADR_W-1:0] last_addr;
    logic [LEN_W-1:0]    words_left;
    logic [IF_W-1:0]     last_data;
    logic [IF_W-1:0]     last_wmask;
    logic [RD_LAT-1:0]   rd_pipe;
    logic [CNT_W-1:0]    outstanding;
    logic [CNT_W-1:0]    fifo_count;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [IF_W-1:0]     fifo_mem [FIFO_DEPTH];

    logic           wr_fire;
    logic           rd_issue;
    logic           capture;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;
    logic           rd_accept;
    logic [CNT_W:0] in_flight;

    // Every issued read is either still in the latency pipe or sitting in the FIFO.
    assign in_flight  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign wr_fire    = (state == S_WRITE) && i_wdata_valid;
    assign rd_issue   = (state == S_READ) && (in_flight < DEPTH_LIMIT);
    assign capture    = rd_pipe[RD_LAT-1];
    assign fifo_empty = (fifo_count == '0);

    // Fall-through: a word arriving into an empty FIFO is presented the same cycle,
    // and only stored if the consumer does not take it right away.
    assign o_rdata_valid = !fifo_empty || capture;
    assign o_rdata       = fifo_empty ? i_data_out : fifo_mem[rd_ptr];
    assign rd_accept     = o_rdata_valid && i_rdata_ready;
    assign fifo_push     = capture && !(fifo_empty && i_rdata_ready);
    assign fifo_pop      = !fifo_empty && i_rdata_ready;

    assign o_cmd_ready   = (state == S_IDLE) && !i_rst;
    assign o_wdata_ready = (state == S_WRITE);
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);
    assign o_wren        = wr_fire;
    assign o_rden        = rd_issue;

    // SRAM address/data/mask hold their last issued values between accesses.
    assign o_address = (wr_fire || rd_issue) ? cur_addr : last_addr;
    assign o_data    = wr_fire ? i_wdata : last_data;
    assign o_wmask   = wr_fire ? i_wdata_mask : last_wmask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            words_left <= '0;
            last_addr  <= '0;
            last_data  <= '0;
            last_wmask <= '0;
        end else begin
            if (wr_fire || rd_issue) begin
                cur_addr   <= cur_addr + ADDR_STEP;
                words_left <= words_left - LEN_W'(1);
                last_addr  <= cur_addr;
            end
            if (wr_fire) begin
                last_data  <= i_wdata;
                last_wmask <= i_wdata_mask;
            end
            unique case (state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        cur_addr   <= i_cmd_addr;
                        words_left <= i_cmd_len;
                        if (i_cmd_len == '0)  state <= S_DONE;
                        else if (i_cmd_write) state <= S_WRITE;
                        else                  state <= S_READ;
                    end
                end
                S_WRITE: if (wr_fire && words_left == LEN_W'(1)) state <= S_DONE;
                S_READ:  if (rd_issue && words_left == LEN_W'(1)) state <= S_DRAIN;
                // Last word leaves when exactly one word remains in flight and it is taken.
                S_DRAIN: if (rd_accept && in_flight == (CNT_W + 1)'(1)) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pipe     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            rd_pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
            outstanding <= outstanding + CNT_W'(rd_issue) - CNT_W'(capture);
            fifo_count  <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            if (fifo_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= i_data_out;
    end
endmodule

// File: tb/tb_sram_burst_initiator.sv
// Purpose: self-checking bench for sram_burst_initiator with a fixed-latency SRAM target model.
// Latency: target returns read data RD_LAT (=2) cycles after each o_rden cycle.
// Backpressure: read consumer ready is either held high or randomised per cycle.
module tb_sram_burst_initiator;
    localparam int IF_W       = 32;
    localparam int IF_ADR_W   = 32;
    localparam int LEN_W      = 16;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = RD_LAT + 2;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_cmd_valid;
    logic                o_cmd_ready;
    logic [IF_ADR_W-1:0] i_cmd_addr;
    logic [LEN_W-1:0]    i_cmd_len;
    logic                i_cmd_write;
    logic                i_wdata_valid;
    logic                o_wdata_ready;
    logic [IF_W-1:0]     i_wdata;
    logic [IF_W-1:0]     i_wdata_mask;
    logic                o_rdata_valid;
    logic                i_rdata_ready;
    logic [IF_W-1:0]     o_rdata;
    logic [IF_W-1:0]     o_data;
    logic [IF_ADR_W-1:0] o_address;
    logic                o_wren;
    logic [IF_W-1:0]     o_wmask;
    logic                o_rden;
    logic [IF_W-1:0]     i_data_out;
    logic                o_busy;
    logic                o_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } wr_exp_t;

    wr_exp_t     wr_exp_q[$];
    logic [31:0] rd_addr_q[$];
    logic [31:0] rd_data_q[$];

    sram_burst_initiator #(
        .IF_W(IF_W), .IF_ADR_W(IF_ADR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_addr(i_cmd_addr),
        .i_cmd_len(i_cmd_len), .i_cmd_write(i_cmd_write),
        .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
        .i_wdata_mask(i_wdata_mask),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
        .o_data(o_data), .o_address(o_address), .o_wren(o_wren), .o_wmask(o_wmask),
        .o_rden(o_rden), .i_data_out(i_data_out), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] adr);
        return {adr[15:0], ~adr[15:0]} ^ 32'h3C3C_0000;
    endfunction

    function automatic logic [31:0] wdata_pat(input int k);
        return 32'hC0DE_0000 + 32'(k * 17);
    endfunction

    function automatic logic [31:0] mask_pat(input int k);
        return 32'hFF00_F0F0 ^ 32'(k);
    endfunction

    // SRAM target: data for an o_rden in cycle t is on i_data_out during cycle t+2.
    logic        t1_vld = 1'b0;
    logic        t2_vld = 1'b0;
    logic [31:0] t1_adr = '0;
    logic [31:0] t2_adr = '0;
    always @(posedge i_clk) begin
        t1_vld <= o_rden;
        t1_adr <= o_address;
        t2_vld <= t1_vld;
        t2_adr <= t1_adr;
    end
    assign i_data_out = t2_vld ? mem_word(t2_adr) : 32'hBAD0_BAD0;

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        #1;
        checks++;
        if ({o_cmd_ready, o_busy, o_wren, o_rden, o_rdata_valid, o_wdata_ready, o_done} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/busy/wren/rden/rvld/wrdy/done=%b, want 0000000",
                     {o_cmd_ready, o_busy, o_wren, o_rden, o_rdata_valid, o_wdata_ready, o_done});
        end
        checks++;
        if (o_address !== 32'h0 || o_data !== 32'h0 || o_wmask !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h mask=%h, want all 0", o_address, o_data, o_wmask);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b, want 1/0", o_cmd_ready, o_busy);
        end
    endtask

    task automatic test_write(input string name, input logic [31:0] addr, input int len);
        wr_exp_t     e;
        int          wr_seen   = 0;
        int          done_seen = 0;
        int          first_wr  = -1;
        int          last_wr   = -1;
        bit          finished  = 0;
        logic [31:0] a         = addr;
        logic [31:0] last_addr = addr + 32'(4 * (len - 1));
        for (int k = 0; k < len; k++) begin
            e.addr = a; e.data = wdata_pat(k); e.mask = mask_pat(k);
            wr_exp_q.push_back(e);
            a = a + 32'd4;
        end
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_len = LEN_W'(len); i_cmd_write = 1'b1;
        i_wdata_valid = 1'b1; i_wdata = 32'hDEAD_0000; i_wdata_mask = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_wren !== 1'b0 || o_wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: got cmd_ready=%b wren=%b wdata_ready=%b, want 1/0/0",
                     name, o_cmd_ready, o_wren, o_wdata_ready);
        end
        for (int cyc = 1; cyc <= 40 && !finished; cyc++) begin
            @(negedge i_clk);
            i_cmd_valid = 1'b0;
            i_wdata = wdata_pat(wr_seen); i_wdata_mask = mask_pat(wr_seen);
            #1;
            checks++;
            if (o_rden !== 1'b0) begin
                errors++;
                $display("FAIL %s_no_rden: got o_rden=%b in cycle %0d, want 0", name, o_rden, cyc);
            end
            if (o_wren === 1'b1) begin
                if (first_wr < 0) first_wr = cyc;
                checks++;
                if (wr_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_write: got write at addr %h, want no more writes", name, o_address);
                end else begin
                    e = wr_exp_q.pop_front();
                    if (o_address !== e.addr || o_data !== e.data || o_wmask !== e.mask) begin
                        errors++;
                        $display("FAIL %s_write%0d: got addr=%h data=%h mask=%h, want addr=%h data=%h mask=%h",
                                 name, wr_seen, o_address, o_data, o_wmask, e.addr, e.data, e.mask);
                    end
                end
                checks++;
                if (cyc != first_wr + wr_seen) begin
                    errors++;
                    $display("FAIL %s_consecutive: got write %0d in cycle %0d, want cycle %0d",
                             name, wr_seen, cyc, first_wr + wr_seen);
                end
                last_wr = cyc;
                wr_seen++;
            end
            if (o_done === 1'b1) begin
                done_seen++;
                checks++;
                if (cyc != last_wr + 1 || wr_seen != len) begin
                    errors++;
                    $display("FAIL %s_done_timing: got done in cycle %0d after %0d writes, want cycle %0d after %0d",
                             name, cyc, wr_seen, last_wr + 1, len);
                end
            end else if (done_seen > 0) begin
                finished = 1;
                checks++;
                if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_address !== last_addr) begin
                    errors++;
                    $display("FAIL %s_idle_after: got cmd_ready=%b busy=%b addr=%h, want 1/0/%h",
                             name, o_cmd_ready, o_busy, o_address, last_addr);
                end
            end
        end
        checks++;
        if (wr_seen != len || done_seen != 1 || !finished) begin
            errors++;
            $display("FAIL %s_totals: got %0d writes, %0d done pulses, finished=%0d; want %0d, 1, 1",
                     name, wr_seen, done_seen, finished, len);
        end
        wr_exp_q.delete();
        i_wdata_valid = 1'b0;
    endtask

    task automatic test_read(input string name, input logic [31:0] addr, input int len, input bit rand_ready);
        int          issued    = 0;
        int          accepted  = 0;
        int          done_seen = 0;
        int          first_rd  = -1;
        int          last_acc  = -1;
        bit          finished  = 0;
        logic [31:0] a         = addr;
        logic [31:0] exp_v;
        for (int k = 0; k < len; k++) begin
            rd_addr_q.push_back(a);
            rd_data_q.push_back(mem_word(a));
            a = a + 32'd4;
        end
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_addr = addr; i_cmd_len = LEN_W'(len); i_cmd_write = 1'b0;
        i_rdata_ready = 1'b1;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_rden !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: got cmd_ready=%b rden=%b, want 1/0", name, o_cmd_ready, o_rden);
        end
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge i_clk);
            i_cmd_valid = 1'b0;
            i_rdata_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            checks++;
            if (o_wren !== 1'b0 || o_wdata_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_no_write: got wren=%b wdata_ready=%b in cycle %0d, want 0/0",
                         name, o_wren, o_wdata_ready, cyc);
            end
            if (o_rden === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                issued++;
                checks++;
                exp_v = (rd_addr_q.size() != 0) ? rd_addr_q.pop_front() : 32'hFFFF_FFFF;
                if (o_address !== exp_v) begin
                    errors++;
                    $display("FAIL %s_rd_addr%0d: got %h, want %h", name, issued - 1, o_address, exp_v);
                end
                if (!rand_ready) begin
                    checks++;
                    if (cyc != first_rd + issued - 1) begin
                        errors++;
                        $display("FAIL %s_rd_consecutive: got read %0d in cycle %0d, want cycle %0d",
                                 name, issued - 1, cyc, first_rd + issued - 1);
                    end
                end
            end
            checks++;
            if (issued - accepted > FIFO_DEPTH) begin
                errors++;
                $display("FAIL %s_inflight_bound: got %0d words in flight, want <= %0d",
                         name, issued - accepted, FIFO_DEPTH);
            end
            if (o_rdata_valid === 1'b1 && i_rdata_ready === 1'b1) begin
                checks++;
                exp_v = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 32'hFFFF_FFFF;
                if (o_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL %s_rdata%0d: got %h, want %h", name, accepted, o_rdata, exp_v);
                end
                if (!rand_ready) begin
                    checks++;
                    if (cyc != first_rd + RD_LAT + accepted) begin
                        errors++;
                        $display("FAIL %s_rdata_timing: got word %0d in cycle %0d, want cycle %0d",
                                 name, accepted, cyc, first_rd + RD_LAT + accepted);
                    end
                end
                accepted++;
                last_acc = cyc;
            end
            if (o_done === 1'b1) begin
                done_seen++;
                checks++;
                if (cyc != last_acc + 1 || accepted != len) begin
                    errors++;
                    $display("FAIL %s_done_timing: got done in cycle %0d after %0d words, want cycle %0d after %0d",
                             name, cyc, accepted, last_acc + 1, len);
                end
            end else if (done_seen > 0) begin
                finished = 1;
                checks++;
                if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_idle_after: got cmd_ready=%b busy=%b, want 1/0", name, o_cmd_ready, o_busy);
                end
            end
        end
        checks++;
        if (issued != len || accepted != len || done_seen != 1 || !finished) begin
            errors++;
            $display("FAIL %s_totals: got issued=%0d accepted=%0d done=%0d finished=%0d; want %0d/%0d/1/1",
                     name, issued, accepted, done_seen, finished, len, len);
        end
        rd_addr_q.delete();
        rd_data_q.delete();
        i_rdata_ready = 1'b1;
    endtask

    task automatic test_zero_len();
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h0000_0800; i_cmd_len = '0; i_cmd_write = 1'b1;
        i_wdata_valid = 1'b1; i_wdata = 32'h1234_5678; i_wdata_mask = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_accept: got cmd_ready=%b, want 1", o_cmd_ready);
        end
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        #1;
        checks++;
        if ({o_done, o_busy, o_wren, o_rden, o_cmd_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL zero_len_done: got done/busy/wren/rden/rdy=%b, want 11000",
                     {o_done, o_busy, o_wren, o_rden, o_cmd_ready});
        end
        @(negedge i_clk);
        #1;
        checks++;
        if ({o_done, o_busy, o_wren, o_rden, o_cmd_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL zero_len_idle: got done/busy/wren/rden/rdy=%b, want 00001",
                     {o_done, o_busy, o_wren, o_rden, o_cmd_ready});
        end
        i_wdata_valid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int issued = 0;
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_addr = 32'h0000_0300; i_cmd_len = LEN_W'(8); i_cmd_write = 1'b0;
        i_rdata_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && issued < 3; cyc++) begin
            @(negedge i_clk);
            i_cmd_valid = 1'b0;
            #1;
            if (o_rden === 1'b1) issued++;
        end
        checks++;
        if (issued != 3) begin
            errors++;
            $display("FAIL rst_mid_wait: got %0d reads issued before timeout, want 3", issued);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        checks++;
        if ({o_cmd_ready, o_busy, o_wren, o_rden, o_rdata_valid, o_wdata_ready, o_done} !== 7'b0 ||
            o_address !== 32'h0 || o_data !== 32'h0 || o_wmask !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got ctrl=%b addr=%h data=%h mask=%h, want all 0",
                     {o_cmd_ready, o_busy, o_wren, o_rden, o_rdata_valid, o_wdata_ready, o_done},
                     o_address, o_data, o_wmask);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            checks++;
            if ({o_rdata_valid, o_done, o_rden, o_busy, o_cmd_ready} !== 5'b00001) begin
                errors++;
                $display("FAIL rst_mid_quiet%0d: got rvld/done/rden/busy/rdy=%b, want 00001",
                         cyc, {o_rdata_valid, o_done, o_rden, o_busy, o_cmd_ready});
            end
            @(negedge i_clk);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_write = 1'b0;
        i_wdata_valid = 1'b0; i_wdata = '0; i_wdata_mask = '0;
        i_rdata_ready = 1'b1;

        test_reset();
        test_write("wr_basic", 32'h0000_0100, 4);
        test_read("rd_basic", 32'h0000_0200, 8, 1'b0);
        test_read("rd_backpressure", 32'h0000_0400, 16, 1'b1);
        test_zero_len();
        test_write("wr_wrap", 32'hFFFF_FFFC, 2);
        test_reset_mid_read();
        test_read("rd_after_reset", 32'h0000_0500, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
